// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  localparam int unsigned CCFF_CHAIN_LEN_DEF = 1024;
  localparam int unsigned CCFF_WORD_W_DEF    = 8;

  function automatic int unsigned ccff_cnt_w(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

  function automatic int unsigned ccff_last_bits(input int unsigned chain_len,
                                                 input int unsigned word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

  localparam int unsigned CCFF_LAST_BITS_DEF = ccff_last_bits(CCFF_CHAIN_LEN_DEF, CCFF_WORD_W_DEF);

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in/serial-out word register, MSB first, with a count of bits still to shift.
module ccff_piso #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned NB_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [NB_W-1:0]   nbits_i,
  output logic              ser_o,
  output logic              last_o
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [NB_W-1:0]   nbits_q, nbits_d;

  always_comb begin
    shreg_d = shreg_q;
    nbits_d = nbits_q;
    if (load_i) begin
      shreg_d = data_i;
      nbits_d = nbits_i;
    end else if (shift_i) begin
      shreg_d = shreg_q << 1;
      nbits_d = nbits_q - NB_W'(1);
    end else begin
      shreg_d = shreg_q;
      nbits_d = nbits_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      nbits_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      nbits_q <= nbits_d;
    end
  end

  assign ser_o  = shreg_q[WORD_W-1];
  assign last_o = (nbits_q == NB_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain programming front end: accepts words over valid/ready and
// drives CHAIN_LEN qualified shifts onto the chain head, MSB of each word first.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter  int unsigned CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter  int unsigned WORD_W    = CCFF_WORD_W_DEF,
  localparam int unsigned CNT_W     = ccff_cnt_w(CHAIN_LEN)
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int unsigned NB_W = $clog2(WORD_W + 1);

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [31:0]      rem_s;
  logic [NB_W-1:0]  load_nbits_s;
  logic             accept_s, shifting_s, ser_s, last_s;

  assign accept_s     = (state_q == LOAD) && in_valid;
  assign shifting_s   = (state_q == SHIFT);
  // The final word of a pass may be only partially shifted; its low bits are dropped.
  assign rem_s        = CHAIN_LEN - 32'(bit_cnt_q);
  assign load_nbits_s = (rem_s < WORD_W) ? NB_W'(rem_s) : NB_W'(WORD_W);

  ccff_piso #(
    .WORD_W (WORD_W),
    .NB_W   (NB_W)
  ) u_piso (
    .clk_i   (CK),
    .rst_ni  (RST_N),
    .load_i  (accept_s),
    .shift_i (shifting_s),
    .data_i  (in_data),
    .nbits_i (load_nbits_s),
    .ser_o   (ser_s),
    .last_o  (last_s)
  );

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
        end else begin
          state_d   = state_q;
        end
      end
      LOAD: begin
        if (in_valid) begin
          state_d = SHIFT;
        end else begin
          state_d = LOAD;
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (!last_s) begin
          state_d = SHIFT;
        end else if (bit_cnt_q + CNT_W'(1) == CNT_W'(CHAIN_LEN)) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so reset forces them low without a clock.
  always_comb begin
    in_ready      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      SHIFT: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = ser_s;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: three loaders (16/10/1-bit chains, 8-bit words) driven with random words.
module tb_ccff_chain_loader;

  logic       CK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] start = 3'b000;
  logic [2:0] in_valid = 3'b000;
  logic [2:0] in_ready, head, shen, busy, done;
  logic [7:0] in_data [3];
  logic [4:0] bit_cnt [3];

  bit          exp_q [3][$];
  int          shifted [3];
  int          pulses [3];
  logic [15:0] chain_m [3];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LEN = (g == 0) ? 16 : ((g == 1) ? 10 : 1);
    localparam int unsigned CW  = $clog2(LEN + 1);
    logic [CW-1:0] bc;
    ccff_chain_loader #(.CHAIN_LEN(LEN), .WORD_W(8)) u_dut (
      .CK            (CK),
      .RST_N         (RST_N),
      .start         (start[g]),
      .in_data       (in_data[g]),
      .in_valid      (in_valid[g]),
      .in_ready      (in_ready[g]),
      .ccff_head     (head[g]),
      .ccff_shift_en (shen[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .bit_cnt       (bc)
    );
    assign bit_cnt[g] = 5'(bc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every shift-enable cycle pops the next expected chain-head bit.
  always @(negedge CK) begin
    if (RST_N) begin
      for (int d = 0; d < 3; d++) begin
        if (shen[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("unexpected_shift", 32'd1, 32'd0);
          end else begin
            chk("head_bit", 32'(head[d]), 32'(exp_q[d].pop_front()));
          end
          chk("bit_cnt_run", 32'(bit_cnt[d]), 32'(shifted[d]));
          chk("ready_in_shift", {busy[d], in_ready[d]}, 32'b10);
          shifted[d]++;
          pulses[d]++;
          chain_m[d] = {chain_m[d][14:0], head[d]};
        end else begin
          chk("head_idle", 32'(head[d]), 32'd0);
        end
      end
    end
  end

  task automatic run_pass(input int d, input int len, input logic [15:0] wp,
                          input int gap, input bit chk_lat, input bit start_mid);
    int rem, nw, k, c0, n;
    logic [7:0]  w;
    logic [15:0] exp_chain, mask;
    @(negedge CK);
    start[d] = 1'b1;
    @(posedge CK);
    #1;
    start[d]   = 1'b0;
    c0         = cyc;
    shifted[d] = 0;
    pulses[d]  = 0;
    chain_m[d] = 16'h0;
    @(negedge CK);
    chk("start_entry", {done[d], in_ready[d], busy[d], bit_cnt[d]}, {1'b0, 1'b1, 1'b1, 5'd0});
    exp_chain = 16'h0;
    rem = len;
    nw  = (len + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? wp[15:8] : wp[7:0];
      k = 0;
      while (!in_ready[d] && k < 100) begin
        @(negedge CK);
        k++;
      end
      if (!in_ready[d]) begin
        chk("ready_timeout", 32'd0, 32'd1);
        return;
      end
      if (i > 0) begin
        for (int j = 0; j < gap; j++) begin
          chk("gap_hold", {in_ready[d], shen[d]}, 32'b10);
          @(negedge CK);
        end
      end
      n = (rem < 8) ? rem : 8;
      for (int b = 0; b < n; b++) begin
        exp_q[d].push_back(w[7-b]);
        exp_chain = {exp_chain[14:0], w[7-b]};
      end
      rem -= n;
      in_data[d]  = w;
      in_valid[d] = 1'b1;
      @(posedge CK);
      #1;
      in_valid[d] = 1'b0;
      in_data[d]  = 8'($urandom);
      if (start_mid && i == 0) begin
        @(negedge CK);
        start[d] = 1'b1;
        @(negedge CK);
        start[d] = 1'b0;
      end
    end
    k = 0;
    while (!done[d] && k < 100) begin
      @(negedge CK);
      k++;
    end
    chk("done_reached", 32'(done[d]), 32'd1);
    if (chk_lat) chk("pass_latency", 32'(cyc - c0), 32'd18);
    chk("final_outputs", {busy[d], in_ready[d], shen[d], bit_cnt[d]}, {1'b0, 1'b0, 1'b0, 5'(len)});
    mask = (len >= 16) ? 16'hFFFF : ((16'd1 << len) - 16'd1);
    chk("pulse_count", 32'(pulses[d]), 32'(len));
    chk("chain_image", 32'(chain_m[d] & mask), 32'(exp_chain & mask));
    chk("queue_drained", 32'(exp_q[d].size()), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_data[d] = 8'h00;
      shifted[d] = 0;
      pulses[d]  = 0;
      chain_m[d] = 16'h0;
    end
    #3;
    for (int d = 0; d < 3; d++)
      chk("reset_outputs", {in_ready[d], shen[d], head[d], busy[d], done[d], bit_cnt[d]}, 32'd0);
    #10;
    RST_N = 1'b1;

    // Abort a pass mid-shift with an asynchronous reset.
    @(negedge CK);
    start[0] = 1'b1;
    @(posedge CK);
    #1;
    start[0]   = 1'b0;
    shifted[0] = 0;
    @(negedge CK);
    for (int b = 0; b < 8; b++) exp_q[0].push_back(1'((8'hA5 >> (7 - b)) & 8'h01));
    in_data[0]  = 8'hA5;
    in_valid[0] = 1'b1;
    @(posedge CK);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(negedge CK);
    #2;
    chk("shifting_before_reset", 32'(shen[0]), 32'd1);
    RST_N = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      chk("async_reset_outputs", {in_ready[d], shen[d], head[d], busy[d], done[d], bit_cnt[d]}, 32'd0);
    exp_q[0].delete();
    @(negedge CK);
    #2;
    RST_N = 1'b1;

    run_pass(0, 16, 16'hA53C, 0, 1'b1, 1'b0);
    run_pass(0, 16, 16'hA53C, 5, 1'b0, 1'b1);
    run_pass(1, 10, 16'hFFC0, 0, 1'b0, 1'b0);
    run_pass(1, 10, 16'h5A3F, 2, 1'b0, 1'b0);
    run_pass(2, 1, 16'h8000, 0, 1'b0, 1'b0);
    run_pass(2, 1, 16'h7F00, 0, 1'b0, 1'b0);
    for (int r = 0; r < 10; r++) begin
      int d;
      d = $urandom_range(0, 2);
      run_pass(d, (d == 0) ? 16 : ((d == 1) ? 10 : 1), 16'($urandom),
               $urandom_range(0, 3), 1'b0, (d == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    repeat (3) @(negedge CK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Programming front end for the configuration-chain flip-flops (DFFSRQ/DFF cells); sits directly upstream of the chain head.
- Accepts bitstream words from the host/bitstream port over a valid/ready handshake and serializes them MSB-first onto the chain head.
- Qualifies every chain shift with a shift enable, counts exactly CHAIN_LEN bits, then reports completion.

Parameters:
- CHAIN_LEN, 1024, number of configuration flip-flops in the chain; must be ≥ 1.
- WORD_W, 8, input word width; must be ≥ 1.
- CNT_W, $clog2(CHAIN_LEN+1), localparam: width of the bit counter.

Ports:
- CK  input  1  single clock; also the clock of the chain flip-flops.
- RST_N  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a programming pass.
- in_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- ccff_head  output  1  serial data to the chain head D.
- ccff_shift_en  output  1  chain advances one position on every CK rising edge where this is 1.
- busy  output  1  programming pass in progress.
- done  output  1  CHAIN_LEN bits have been shifted.
- bit_cnt  output  CNT_W  bits shifted so far in the current pass.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State goes to IDLE.
  - in_ready, ccff_shift_en, ccff_head, busy, done and bit_cnt all become 0 immediately, without waiting for CK.
  - The internal shift register clears to 0.
- All other state updates happen on the rising edge of CK.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready=0, busy=0, done=0.
  - start=1 → LOAD; bit_cnt cleared to 0.
- LOAD:
  - in_ready=1, busy=1.
  - in_valid&in_ready at edge t:
    - shreg<=in_data.
    - nbits<=min(WORD_W, CHAIN_LEN-bit_cnt).
    - Next state SHIFT.
  - in_valid=0: hold in LOAD indefinitely; no timeout.
- SHIFT:
  - in_ready=0, busy=1, ccff_shift_en=1, ccff_head=shreg[WORD_W-1] (registered source, glitch-free).
  - Each edge:
    - shreg<=shreg<<1 (zero fill).
    - bit_cnt+=1.
    - nbits-=1.
  - Exit when the edge consumes the last bit (nbits==1):
    - bit_cnt becomes CHAIN_LEN → DONE.
    - Otherwise → LOAD.
- Timing: a word accepted at edge t shifts its bits on edges t+1..t+nbits. Each full word costs WORD_W+1 cycles; there is no overlap between accept and shift.
- Partial last word: if CHAIN_LEN mod WORD_W ≠ 0, the final word shifts only its upper CHAIN_LEN mod WORD_W bits. Its low bits are discarded and never reach the chain.
- DONE:
  - done=1 (level), busy=0, in_ready=0, ccff_shift_en=0.
  - start=1 → LOAD, with bit_cnt cleared and done dropped next cycle.
- start asserted in LOAD or SHIFT is ignored; no restart mid-pass.
- ccff_shift_en is 0 in every state except SHIFT. ccff_head is 0 outside SHIFT.
- bit_cnt never exceeds CHAIN_LEN and holds its final value in DONE.
- Reset mid-SHIFT aborts the pass. Chain contents are then undefined and a full new pass is required; no partial resume.
- in_data is sampled only on the handshake edge; it is don't-care otherwise.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum (IDLE/LOAD/SHIFT/DONE);
  - a function computing CNT_W;
  - the localparam for bits in the final word.
- One natural sub-module: ccff_piso, the WORD_W-bit parallel-in/serial-out register with load, shift and a remaining-bit counter.
- The FSM and bit_cnt live in the top module.

Test Plan:
1. Reset values: RST_N low mid-SHIFT with WORD_W=8, CHAIN_LEN=16 → all outputs 0 asynchronously, state IDLE. After release, start plus 2 words required, done after 18 cycles of activity.
2. Basic pass, CHAIN_LEN=16, WORD_W=8, words 0xA5, 0x3C → ccff_head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on exactly 16 shift_en cycles. A 16-bit chain model reads 0xA53C, bit_cnt=16, done=1.
3. Partial word, CHAIN_LEN=10, WORD_W=8, words 0xFF, 0xC0 → exactly 10 shift_en pulses. The last two bits shifted are 1,1; 0xC0's low 6 bits are never shifted.
4. Backpressure/gaps: in_valid low 5 cycles between words → no shift_en during the gap, in_ready held 1, shifted data identical to scenario 2.
5. Ignored start: pulse start during SHIFT → no restart, bit_cnt monotonic. start in DONE → done drops next cycle, bit_cnt=0, in_ready=1.
6. CHAIN_LEN=1, WORD_W=8, word 0x80 → one shift_en pulse with ccff_head=1, then DONE.
